fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_defs.sv | 38 +++
 rtl/next_pc_mux.sv | 32 +++
 rtl/fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode/funct constants, next-PC select encodings,
// and the fetch FSM state type.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  typedef enum logic [1:0] {
    PCSRC_PLUS4  = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_REG    = 2'd3
  } pc_src_e;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_e;

  function automatic logic branch_taken(input logic beq, input logic bne,
                                        input logic zero);
    return (beq & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection; a not-taken branch selects the current PC.
module next_pc_mux
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        alu_zero,
  input  logic [31:0] alu_out,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_a,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc    = pc + 32'd4;
    misaligned = 1'b0;
    case (pc_src_e'(pc_src))
      PCSRC_PLUS4:  next_pc = pc + 32'd4;
      PCSRC_BRANCH: next_pc = branch_taken(branch_eq, branch_ne, alu_zero) ? alu_out : pc;
      PCSRC_JUMP:   next_pc = {pc[31:28], jump_index, 2'b00};
      PCSRC_REG: begin
        next_pc    = {reg_a[31:2], 2'b00};
        misaligned = |reg_a[1:0];
      end
      default:      next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/WAIT fetch FSM plus PC, IR and link registers.
module fetch_unit
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_we,
  input  logic [1:0]  pc_src,
  input  logic        ir_we,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jal,
  input  logic        alu_zero,
  input  logic [31:0] alu_out,
  input  logic [31:0] reg_a,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        stall,
  output logic [31:0] link_addr,
  output logic        link_we,
  output logic        misalign
);

  fetch_state_e state, state_next;
  logic         ir_capture;
  logic         pc_update;
  logic [31:0]  next_pc;
  logic         target_misaligned;

  next_pc_mux u_next_pc_mux (
    .pc         (pc),
    .pc_src     (pc_src),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .alu_zero   (alu_zero),
    .alu_out    (alu_out),
    .jump_index (instruction[25:0]),
    .reg_a      (reg_a),
    .next_pc    (next_pc),
    .misaligned (target_misaligned)
  );

  // A fetch that misses in IDLE also blocks the PC write on that same edge.
  always_comb begin
    state_next = state;
    ir_capture = 1'b0;
    pc_update  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if (ir_we) begin
          if (mem_valid) ir_capture = 1'b1;
          else           state_next = FETCH_WAIT;
        end
        pc_update = pc_we & ~(ir_we & ~mem_valid);
      end
      FETCH_WAIT: begin
        if (mem_valid) begin
          ir_capture = 1'b1;
          state_next = FETCH_IDLE;
        end
      end
      default: state_next = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH_IDLE;
      pc          <= '0;
      instruction <= '0;
      link_addr   <= '0;
      link_we     <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state   <= state_next;
      link_we <= pc_update & jal;
      if (ir_capture) instruction <= mem_rdata;
      if (pc_update) pc <= next_pc;
      if (pc_update && jal) link_addr <= pc;
      if (pc_update && target_misaligned) misalign <= 1'b1;
    end
  end

  assign stall = (state == FETCH_WAIT);

endmodule
